mac_tx_framer: RTL and testbench
================================

Name: mac_tx_framer

Overview:
Transmit-side framer for the Ethernet MAC. It drains a frame's bytes from the transmit byte FIFO (fifo_buffer read port) and drives a GMII-style byte stream. The stream is preamble, SFD, payload, zero padding, CRC-32 FCS, then the inter-frame gap. It sits between the TX FIFO and the PHY interface, in the opposite direction to the receive path that fills the RX FIFO.

Parameters:
PREAMBLE_LEN, 7, number of 0x55 bytes before the SFD
MIN_LEN, 60, minimum bytes before the FCS; shorter frames are zero-padded up to this
MAX_LEN, 1514, largest legal frame_len
IFG_LEN, 12, idle cycles after the FCS before the next start is accepted

Ports:
clk  in  1  single system clock
rst  in  1  reset; one clock, synchronous, active-high
start  in  1  frame request; sampled only when busy=0
frame_len  in  11  payload byte count in the FIFO (DA through last data byte); sampled with start
fifo_dout  in  8  FIFO read data; valid the cycle after fifo_rd_en
fifo_empty  in  1  FIFO empty flag
fifo_rd_en  out  1  FIFO pop request; combinational, never asserted while fifo_empty=1
txd  out  8  transmit byte, registered
tx_en  out  1  transmit enable, registered
tx_er  out  1  transmit error, registered
busy  out  1  high from the cycle after start is accepted until the IFG ends
done  out  1  one-cycle pulse on the last IFG cycle of a completed frame
underrun  out  1  one-cycle pulse when the FIFO runs dry mid-payload
len_err  out  1  one-cycle pulse when start is given with an illegal frame_len

Behaviour:
- Reset (synchronous) drives the following to 0 on the next edge: txd, tx_en, tx_er, busy, done, underrun, len_err. State returns to IDLE and fifo_rd_en is 0. FIFO contents are not flushed.
- States: IDLE -> PRE -> SFD -> DATA -> PAD -> FCS -> IFG -> IDLE.
- Start acceptance:
  - start with busy=0 and 1<=frame_len<=MAX_LEN: latch L=frame_len and go to PRE.
  - start with an illegal frame_len: len_err pulses on the next cycle and the block stays in IDLE.
  - start while busy=1 is ignored.
- Output timing, with acceptance at cycle 0 and P=max(L,MIN_LEN):
  - cycles 1..7: txd=0x55.
  - cycle 8: txd=0xD5.
  - cycles 9..8+L: payload.
  - cycles 9+L..8+P: txd=0x00 (padding).
  - next 4 cycles: FCS, least-significant byte first.
  - tx_en=1 for exactly 8+P+4 cycles.
  - then tx_en=0 and txd=0 for IFG_LEN cycles; done pulses and busy clears on the last IFG cycle.
- FIFO reads:
  - fifo_rd_en for payload byte i (0-based) is asserted in cycle 7+i.
  - fifo_dout is captured at 8+i and appears on txd at 9+i.
  - exactly L pops per good frame; no pops in PAD, FCS or IFG.
- CRC: reflected CRC-32, polynomial 0xEDB88320, init 0xFFFFFFFF. It covers payload plus pad, one byte per cycle. FCS = bitwise NOT of the final CRC.
- Underrun: if fifo_empty=1 in cycle 7+i (i<L):
  - no pop.
  - cycle 9+i: tx_en=1, tx_er=1, txd=0x00, underrun pulses.
  - from cycle 10+i: tx_en=0 and the full IFG runs; no FCS is sent and done does not pulse.
  - busy stays high through the IFG.
- Counters are 11 bits wide and never wrap, because L<=1514.
- tx_er is 0 at all times except the underrun cycle.

Decomposition:
- Package mac_pkg holds:
  - the state enum;
  - PREAMBLE_BYTE=8'h55 and SFD_BYTE=8'hD5;
  - CRC_POLY=32'hEDB88320 and CRC_INIT=32'hFFFFFFFF;
  - LEN_W=11.
- Sub-module crc32_byte: a combinational next-CRC function (crc_in[31:0], data[7:0] -> crc_out[31:0]). The CRC register itself lives in the framer.

Test Plan:
1. crc32_byte alone, fed ASCII "123456789" from CRC_INIT -> final NOT equals 0xCBF43926.
2. FIFO preloaded with 64 bytes, start with L=64:
   - 7x55, D5, the 64 bytes in order, 4 FCS bytes matching the model;
   - tx_en high for 76 cycles, 64 pops, 12 idle cycles, done pulse, busy=0.
3. L=20:
   - 20 payload bytes, then 40 bytes of 0x00;
   - tx_en high for 72 cycles, exactly 20 pops, FCS covers 60 bytes.
4. FIFO holds 10 bytes, L=64:
   - 10 payload bytes, then tx_er=1 with txd=00 at cycle 19 and an underrun pulse;
   - no FCS, no done, busy clears after the IFG.
5. Length and busy checks:
   - start with frame_len=0, then 1515 -> a len_err pulse each, busy stays 0, no pops;
   - start asserted mid-frame -> ignored.
6. rst at cycle 30 of a frame:
   - next cycle all outputs are 0 and fifo_rd_en=0;
   - a subsequent start with L=60 transmits normally.

Source files
------------

// File: rtl/mac_tx_framer_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the MAC transmit framer:
//   - tx_state_e    : framer state encoding
//   - PREAMBLE_BYTE : preamble octet (0x55)
//   - SFD_BYTE      : start-of-frame delimiter (0xD5)
//   - CRC_POLY      : reflected CRC-32 polynomial
//   - CRC_INIT      : CRC-32 seed value
//   - LEN_W         : width of all length/byte counters
//   - crc32_next    : one-byte reflected CRC-32 update
// -----------------------------------------------------------------------------
package mac_pkg;

    localparam int          LEN_W         = 11;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PRE  = 3'd1,
        ST_SFD  = 3'd2,
        ST_DATA = 3'd3,
        ST_PAD  = 3'd4,
        ST_FCS  = 3'd5,
        ST_IFG  = 3'd6
    } tx_state_e;

    // Reflected CRC-32: the data byte enters at the LSB end and the register
    // shifts right once per bit, folding in the polynomial when a 1 drops out.
    function automatic logic [31:0] crc32_next(input logic [31:0] crc,
                                               input logic [7:0]  data);
        logic [31:0] c;
        c = crc ^ {24'h000000, data};
        for (int b = 0; b < 8; b++) begin
            if (c[0]) begin
                c = (c >> 1) ^ CRC_POLY;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

endpackage

// File: rtl/mac_tx_framer_if.sv
// -----------------------------------------------------------------------------
// mac_tx_framer_if
// Read port of the transmit byte FIFO as seen by the framer.
//   fifo_rd_en : pop request (framer -> FIFO)
//   fifo_dout  : read data, valid the cycle after a pop (FIFO -> framer)
//   fifo_empty : FIFO empty flag (FIFO -> framer)
// Modports: master = framer side, slave = FIFO side.
// -----------------------------------------------------------------------------
interface mac_tx_framer_if;

    logic       fifo_rd_en;
    logic [7:0] fifo_dout;
    logic       fifo_empty;

    modport master (
        output fifo_rd_en,
        input  fifo_dout,
        input  fifo_empty
    );

    modport slave (
        input  fifo_rd_en,
        output fifo_dout,
        output fifo_empty
    );

endinterface

// File: rtl/mac_tx_framer_crc32_byte.sv
// -----------------------------------------------------------------------------
// crc32_byte
// Combinational next-state of the reflected CRC-32 for one data byte.
//   crc_in  [31:0] : current CRC register value
//   data    [7:0]  : byte to fold in
//   crc_out [31:0] : CRC after absorbing data
// The CRC register itself belongs to the caller.
// -----------------------------------------------------------------------------
module crc32_byte
    import mac_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    assign crc_out = crc32_next(crc_in, data);

endmodule

// File: rtl/mac_tx_framer.sv
// -----------------------------------------------------------------------------
// mac_tx_framer
// Drains one frame from the TX byte FIFO and emits a GMII-style byte stream:
// preamble, SFD, payload, zero padding up to MIN_LEN, CRC-32 FCS (LSB first),
// then IFG_LEN idle cycles.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   start,frame_len : frame request and payload length, sampled when idle
//   fifo            : FIFO read port (master side)
//   txd,tx_en,tx_er : registered transmit stream
//   busy            : frame in progress (through the IFG)
//   done            : pulse on the last IFG cycle of a good frame
//   underrun        : pulse when the FIFO ran dry mid-payload
//   len_err         : pulse when start carried an illegal length
// -----------------------------------------------------------------------------
module mac_tx_framer
    import mac_pkg::*;
#(
    parameter int PREAMBLE_LEN = 7,
    parameter int MIN_LEN      = 60,
    parameter int MAX_LEN      = 1514,
    parameter int IFG_LEN      = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] frame_len,
    mac_tx_framer_if.master  fifo,
    output logic [7:0]       txd,
    output logic             tx_en,
    output logic             tx_er,
    output logic             busy,
    output logic             done,
    output logic             underrun,
    output logic             len_err
);

    localparam logic [LEN_W-1:0] PRE_LAST_C  = LEN_W'(PREAMBLE_LEN - 1);
    localparam logic [LEN_W-1:0] MIN_LEN_C   = LEN_W'(MIN_LEN);
    localparam logic [LEN_W-1:0] MAX_LEN_C   = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] IFG_LAST_C  = LEN_W'(IFG_LEN - 1);
    localparam logic [LEN_W-1:0] FCS_BYTES_C = LEN_W'(4);

    tx_state_e        state_r;
    logic [LEN_W-1:0] cnt_r;       // position within the current state
    logic [LEN_W-1:0] len_r;       // latched payload length L
    logic [LEN_W-1:0] pad_len_r;   // max(L, MIN_LEN)
    logic [LEN_W-1:0] rd_cnt_r;    // pops issued for this frame
    logic             miss_r;      // a due pop found the FIFO empty
    logic [31:0]      crc_r;

    logic             rd_window_s;
    logic             rd_due_s;
    logic [7:0]       crc_data_s;
    logic [31:0]      crc_next_s;
    logic [31:0]      fcs_s;
    logic             len_ok_s;

    // Pops run one cycle ahead of the byte being sent: from the last preamble
    // cycle through DATA, until L pops have been issued or one has missed.
    always_comb begin
        rd_window_s = 1'b0;
        case (state_r)
            ST_PRE:          rd_window_s = (cnt_r == PRE_LAST_C);
            ST_SFD, ST_DATA: rd_window_s = 1'b1;
            default:         rd_window_s = 1'b0;
        endcase
        rd_due_s = rd_window_s && (rd_cnt_r < len_r) && !miss_r;
        if (cnt_r < len_r) begin
            crc_data_s = fifo.fifo_dout;
        end else begin
            crc_data_s = 8'h00;
        end
    end

    assign fifo.fifo_rd_en = rd_due_s && !fifo.fifo_empty;
    assign fcs_s           = ~crc_r;
    assign len_ok_s        = (frame_len != {LEN_W{1'b0}}) && (frame_len <= MAX_LEN_C);

    crc32_byte u_crc (
        .crc_in  (crc_r),
        .data    (crc_data_s),
        .crc_out (crc_next_s)
    );

    // Framer sequencer; each edge loads the byte shown in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {LEN_W{1'b0}};
            len_r     <= {LEN_W{1'b0}};
            pad_len_r <= {LEN_W{1'b0}};
            rd_cnt_r  <= {LEN_W{1'b0}};
            miss_r    <= 1'b0;
            crc_r     <= CRC_INIT;
            txd       <= 8'h00;
            tx_en     <= 1'b0;
            tx_er     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            underrun  <= 1'b0;
            len_err   <= 1'b0;
        end else begin
            done     <= 1'b0;
            underrun <= 1'b0;
            len_err  <= 1'b0;
            tx_er    <= 1'b0;
            if (fifo.fifo_rd_en) begin
                rd_cnt_r <= rd_cnt_r + LEN_W'(1);
            end
            if (rd_due_s && fifo.fifo_empty) begin
                miss_r <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    txd   <= 8'h00;
                    tx_en <= 1'b0;
                    if (start) begin
                        if (len_ok_s) begin
                            state_r   <= ST_PRE;
                            cnt_r     <= {LEN_W{1'b0}};
                            len_r     <= frame_len;
                            pad_len_r <= (frame_len < MIN_LEN_C) ? MIN_LEN_C : frame_len;
                            rd_cnt_r  <= {LEN_W{1'b0}};
                            miss_r    <= 1'b0;
                            crc_r     <= CRC_INIT;
                            busy      <= 1'b1;
                            txd       <= PREAMBLE_BYTE;
                            tx_en     <= 1'b1;
                        end else begin
                            len_err <= 1'b1;
                        end
                    end
                end
                ST_PRE: begin
                    if (cnt_r == PRE_LAST_C) begin
                        txd     <= SFD_BYTE;
                        state_r <= ST_SFD;
                        cnt_r   <= {LEN_W{1'b0}};
                    end else begin
                        txd   <= PREAMBLE_BYTE;
                        cnt_r <= cnt_r + LEN_W'(1);
                    end
                end
                // cnt_r counts bytes already sent after the SFD.
                ST_SFD, ST_DATA, ST_PAD: begin
                    if (cnt_r < len_r) begin
                        if (miss_r) begin
                            // Abort: one errored byte, then straight into the IFG.
                            txd      <= 8'h00;
                            tx_er    <= 1'b1;
                            underrun <= 1'b1;
                            state_r  <= ST_IFG;
                            cnt_r    <= {LEN_W{1'b0}};
                        end else begin
                            txd     <= fifo.fifo_dout;
                            crc_r   <= crc_next_s;
                            cnt_r   <= cnt_r + LEN_W'(1);
                            state_r <= ST_DATA;
                        end
                    end else if (cnt_r < pad_len_r) begin
                        txd     <= 8'h00;
                        crc_r   <= crc_next_s;
                        cnt_r   <= cnt_r + LEN_W'(1);
                        state_r <= ST_PAD;
                    end else begin
                        txd     <= fcs_s[7:0];
                        state_r <= ST_FCS;
                        cnt_r   <= LEN_W'(1);
                    end
                end
                ST_FCS: begin
                    if (cnt_r < FCS_BYTES_C) begin
                        txd   <= fcs_s[{cnt_r[1:0], 3'b000} +: 8];
                        cnt_r <= cnt_r + LEN_W'(1);
                    end else begin
                        txd     <= 8'h00;
                        tx_en   <= 1'b0;
                        state_r <= ST_IFG;
                        cnt_r   <= LEN_W'(1);
                    end
                end
                // The last IFG cycle is spent in IDLE so start is accepted there.
                ST_IFG: begin
                    txd   <= 8'h00;
                    tx_en <= 1'b0;
                    if (cnt_r == IFG_LAST_C) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= {LEN_W{1'b0}};
                        busy    <= 1'b0;
                        done    <= !miss_r;
                    end else begin
                        cnt_r <= cnt_r + LEN_W'(1);
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    txd     <= 8'h00;
                    tx_en   <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mac_tx_framer.sv
// -----------------------------------------------------------------------------
// tb_mac_tx_framer
// Directed bench for mac_tx_framer with a behavioural FIFO on the read port.
// Cycle k of a frame is the k-th clock period after the accepting edge;
// inputs change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mac_tx_framer;
    import mac_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [10:0] frame_len;
    logic [7:0]  txd;
    logic        tx_en, tx_er, busy, done, underrun, len_err;

    mac_tx_framer_if fifo_if ();

    mac_tx_framer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .frame_len (frame_len),
        .fifo      (fifo_if),
        .txd       (txd),
        .tx_en     (tx_en),
        .tx_er     (tx_er),
        .busy      (busy),
        .done      (done),
        .underrun  (underrun),
        .len_err   (len_err)
    );

    logic [31:0] ut_crc_in;
    logic [7:0]  ut_data;
    logic [31:0] ut_crc_out;

    crc32_byte u_crc_ut (
        .crc_in  (ut_crc_in),
        .data    (ut_data),
        .crc_out (ut_crc_out)
    );

    always #5 clk = ~clk;

    // Behavioural FIFO: data appears on fifo_dout the cycle after a pop.
    logic [7:0] mem [0:1023];
    logic [9:0] wr_ptr = 10'd0;
    logic [9:0] rd_ptr = 10'd0;

    always @(posedge clk) begin
        if (fifo_if.fifo_rd_en) begin
            fifo_if.fifo_dout <= mem[rd_ptr];
            rd_ptr            <= rd_ptr + 10'd1;
        end
    end
    assign fifo_if.fifo_empty = (rd_ptr == wr_ptr);

    int n_err    = 0;
    int n_checks = 0;
    int pop_empty = 0;

    logic [7:0] exp_b    [0:127];
    logic [7:0] rec_txd  [0:127];
    logic       rec_en   [0:127];
    logic       rec_er   [0:127];
    logic       rec_rd   [0:127];
    logic       rec_done [0:127];
    logic       rec_busy [0:127];
    logic       rec_ur   [0:127];
    logic       rec_lerr [0:127];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] crc_model(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc ^ {24'h000000, d};
        for (int b = 0; b < 8; b++) begin
            c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    task automatic push(input logic [7:0] b);
        mem[wr_ptr] = b;
        wr_ptr = wr_ptr + 10'd1;
    endtask

    // Start a frame and record ncyc cycles; optionally pulse start (len 5)
    // at inj_cyc and rst at rst_cyc.
    task automatic run(input int len, input int ncyc, input int inj_cyc, input int rst_cyc);
        @(negedge clk);
        start     = 1'b1;
        frame_len = 11'(len);
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            rec_txd[k]  = txd;
            rec_en[k]   = tx_en;
            rec_er[k]   = tx_er;
            rec_rd[k]   = fifo_if.fifo_rd_en;
            rec_done[k] = done;
            rec_busy[k] = busy;
            rec_ur[k]   = underrun;
            rec_lerr[k] = len_err;
            if (fifo_if.fifo_rd_en && fifo_if.fifo_empty) pop_empty++;
            start     = (k == inj_cyc) ? 1'b1 : 1'b0;
            frame_len = (k == inj_cyc) ? 11'd5 : frame_len;
            rst       = (k == rst_cyc) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        rst   = 1'b0;
    endtask

    // Full-frame expectations for a good frame of length len, payload in exp_b.
    task automatic check_good_frame(input string tag, input int len);
        int p;
        int n_en, n_rd, n_done, n_er, n_ur, n_le;
        logic [31:0] c;
        p = (len < 60) ? 60 : len;
        n_en = 0; n_rd = 0; n_done = 0; n_er = 0; n_ur = 0; n_le = 0;
        c = 32'hFFFFFFFF;
        for (int k = 1; k <= 7; k++) check($sformatf("%s_pre%0d", tag, k), 32'(rec_txd[k]), 32'h55);
        check($sformatf("%s_sfd", tag), 32'(rec_txd[8]), 32'hD5);
        for (int i = 0; i < len; i++) begin
            check($sformatf("%s_pay%0d", tag, i), 32'(rec_txd[9 + i]), 32'(exp_b[i]));
            c = crc_model(c, exp_b[i]);
        end
        for (int i = len; i < p; i++) begin
            check($sformatf("%s_pad%0d", tag, i), 32'(rec_txd[9 + i]), 32'h00);
            c = crc_model(c, 8'h00);
        end
        c = ~c;
        for (int j = 0; j < 4; j++)
            check($sformatf("%s_fcs%0d", tag, j), 32'(rec_txd[9 + p + j]), 32'(c[8*j +: 8]));
        for (int k = 1; k <= p + 26; k++) begin
            n_en   += int'(rec_en[k]);
            n_rd   += int'(rec_rd[k]);
            n_done += int'(rec_done[k]);
            n_er   += int'(rec_er[k]);
            n_ur   += int'(rec_ur[k]);
            n_le   += int'(rec_lerr[k]);
        end
        check($sformatf("%s_en_cycles", tag), 32'(n_en), 32'(12 + p));
        check($sformatf("%s_en_last", tag), 32'(rec_en[12 + p]), 32'd1);
        check($sformatf("%s_en_off", tag), 32'(rec_en[13 + p]), 32'd0);
        check($sformatf("%s_ifg_txd", tag), 32'(rec_txd[13 + p]), 32'h00);
        check($sformatf("%s_pops", tag), 32'(n_rd), 32'(len));
        check($sformatf("%s_pop_first", tag), 32'(rec_rd[7]), 32'd1);
        check($sformatf("%s_pop_early", tag), 32'(rec_rd[6]), 32'd0);
        check($sformatf("%s_pop_last", tag), 32'(rec_rd[6 + len]), 32'd1);
        check($sformatf("%s_tx_er", tag), 32'(n_er), 32'd0);
        check($sformatf("%s_underrun", tag), 32'(n_ur), 32'd0);
        check($sformatf("%s_len_err", tag), 32'(n_le), 32'd0);
        check($sformatf("%s_done_cnt", tag), 32'(n_done), 32'd1);
        check($sformatf("%s_done_at", tag), 32'(rec_done[24 + p]), 32'd1);
        check($sformatf("%s_busy_first", tag), 32'(rec_busy[1]), 32'd1);
        check($sformatf("%s_busy_ifg", tag), 32'(rec_busy[23 + p]), 32'd1);
        check($sformatf("%s_busy_end", tag), 32'(rec_busy[24 + p]), 32'd0);
    endtask

    initial begin
        logic [31:0] c;
        string s;
        int n_en, n_rd, n_done, n_er, n_ur;

        rst       = 1'b1;
        start     = 1'b0;
        frame_len = 11'd0;

        // 1: CRC check value of "123456789"
        s = "123456789";
        c = CRC_INIT;
        for (int i = 0; i < 9; i++) begin
            ut_crc_in = c;
            ut_data   = s[i];
            #1;
            c = ut_crc_out;
        end
        check("crc_check_value", ~c, 32'hCBF43926);

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_txd", 32'(txd), 32'h00);
        check("rst_tx_en", 32'(tx_en), 32'd0);
        check("rst_tx_er", 32'(tx_er), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        check("rst_len_err", 32'(len_err), 32'd0);
        check("rst_rd_en", 32'(fifo_if.fifo_rd_en), 32'd0);
        rst = 1'b0;

        // 2: 64-byte frame, with an ignored start at cycle 20
        for (int i = 0; i < 64; i++) begin
            exp_b[i] = 8'((i * 7 + 3) % 256);
            push(exp_b[i]);
        end
        run(64, 90, 20, 0);
        check_good_frame("f64", 64);

        // 3: 20-byte frame padded to 60
        for (int i = 0; i < 20; i++) begin
            exp_b[i] = 8'hA0 ^ 8'(i);
            push(exp_b[i]);
        end
        run(20, 86, 0, 0);
        check_good_frame("f20", 20);

        // 4: underrun after 10 bytes of a 64-byte frame
        for (int i = 0; i < 10; i++) begin
            exp_b[i] = 8'(i + 1);
            push(exp_b[i]);
        end
        run(64, 40, 0, 0);
        for (int i = 0; i < 10; i++)
            check($sformatf("ur_pay%0d", i), 32'(rec_txd[9 + i]), 32'(exp_b[i]));
        n_en = 0; n_rd = 0; n_done = 0; n_er = 0; n_ur = 0;
        for (int k = 1; k <= 40; k++) begin
            n_en   += int'(rec_en[k]);
            n_rd   += int'(rec_rd[k]);
            n_done += int'(rec_done[k]);
            n_er   += int'(rec_er[k]);
            n_ur   += int'(rec_ur[k]);
        end
        check("ur_err_txd", 32'(rec_txd[19]), 32'h00);
        check("ur_err_en", 32'(rec_en[19]), 32'd1);
        check("ur_err_er", 32'(rec_er[19]), 32'd1);
        check("ur_pulse", 32'(rec_ur[19]), 32'd1);
        check("ur_er_before", 32'(rec_er[18]), 32'd0);
        check("ur_en_after", 32'(rec_en[20]), 32'd0);
        check("ur_en_cycles", 32'(n_en), 32'd19);
        check("ur_er_cnt", 32'(n_er), 32'd1);
        check("ur_pulse_cnt", 32'(n_ur), 32'd1);
        check("ur_pops", 32'(n_rd), 32'd10);
        check("ur_no_done", 32'(n_done), 32'd0);
        check("ur_busy_ifg", 32'(rec_busy[30]), 32'd1);
        check("ur_busy_end", 32'(rec_busy[32]), 32'd0);

        // 5: illegal lengths with a non-empty FIFO
        for (int i = 0; i < 60; i++) begin
            exp_b[i] = 8'h40 + 8'(i);
            push(exp_b[i]);
        end
        @(negedge clk);
        start = 1'b1; frame_len = 11'd0;
        @(negedge clk);
        start = 1'b0;
        check("len0_err", 32'(len_err), 32'd1);
        check("len0_busy", 32'(busy), 32'd0);
        check("len0_rd", 32'(fifo_if.fifo_rd_en), 32'd0);
        @(negedge clk);
        check("len0_pulse_end", 32'(len_err), 32'd0);
        start = 1'b1; frame_len = 11'd1515;
        @(negedge clk);
        start = 1'b0;
        check("len1515_err", 32'(len_err), 32'd1);
        check("len1515_busy", 32'(busy), 32'd0);
        check("len1515_en", 32'(tx_en), 32'd0);
        @(negedge clk);
        check("len1515_pulse_end", 32'(len_err), 32'd0);
        check("len1515_rd", 32'(fifo_if.fifo_rd_en), 32'd0);

        // 6: reset at cycle 30 of a 60-byte frame; pops happen in cycles 7..30
        run(60, 31, 0, 30);
        n_rd = 0;
        for (int k = 1; k <= 31; k++) n_rd += int'(rec_rd[k]);
        check("rstf_pay21", 32'(rec_txd[30]), 32'(exp_b[21]));
        check("rstf_pops", 32'(n_rd), 32'd24);
        check("rstf_txd", 32'(rec_txd[31]), 32'h00);
        check("rstf_en", 32'(rec_en[31]), 32'd0);
        check("rstf_er", 32'(rec_er[31]), 32'd0);
        check("rstf_busy", 32'(rec_busy[31]), 32'd0);
        check("rstf_done", 32'(rec_done[31]), 32'd0);
        check("rstf_ur", 32'(rec_ur[31]), 32'd0);
        check("rstf_lerr", 32'(rec_lerr[31]), 32'd0);
        check("rstf_rd", 32'(rec_rd[31]), 32'd0);

        // The FIFO keeps bytes 24..59 of the aborted frame; top up with 24 more.
        for (int i = 0; i < 36; i++) exp_b[i] = 8'h40 + 8'(24 + i);
        for (int i = 0; i < 24; i++) begin
            exp_b[36 + i] = 8'hC0 + 8'(i);
            push(exp_b[36 + i]);
        end
        run(60, 86, 0, 0);
        check_good_frame("f60", 60);

        check("pop_while_empty", 32'(pop_empty), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
